// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared constants and helpers for the seven-segment scan
//               driver. Holds the 16-entry hex segment encoding (active-low,
//               bit order {a,b,c,d,e,f,g}, MSB = a), the blank pattern, the
//               nibble-to-segment function and a width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Segment patterns, 0 = segment lit.
    localparam logic [6:0] c_SEG_0     = 7'b0000001;
    localparam logic [6:0] c_SEG_1     = 7'b1001111;
    localparam logic [6:0] c_SEG_2     = 7'b0010010;
    localparam logic [6:0] c_SEG_3     = 7'b0000110;
    localparam logic [6:0] c_SEG_4     = 7'b1001100;
    localparam logic [6:0] c_SEG_5     = 7'b0100100;
    localparam logic [6:0] c_SEG_6     = 7'b0100000;
    localparam logic [6:0] c_SEG_7     = 7'b0001111;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0000100;
    localparam logic [6:0] c_SEG_A     = 7'b0001000;
    localparam logic [6:0] c_SEG_B     = 7'b1100000;
    localparam logic [6:0] c_SEG_C     = 7'b0110001;
    localparam logic [6:0] c_SEG_D     = 7'b1000010;
    localparam logic [6:0] c_SEG_E     = 7'b0110000;
    localparam logic [6:0] c_SEG_F     = 7'b0111000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = c_SEG_BLANK;
        case (nibble)
            4'h0: seg = c_SEG_0;
            4'h1: seg = c_SEG_1;
            4'h2: seg = c_SEG_2;
            4'h3: seg = c_SEG_3;
            4'h4: seg = c_SEG_4;
            4'h5: seg = c_SEG_5;
            4'h6: seg = c_SEG_6;
            4'h7: seg = c_SEG_7;
            4'h8: seg = c_SEG_8;
            4'h9: seg = c_SEG_9;
            4'hA: seg = c_SEG_A;
            4'hB: seg = c_SEG_B;
            4'hC: seg = c_SEG_C;
            4'hD: seg = c_SEG_D;
            4'hE: seg = c_SEG_E;
            4'hF: seg = c_SEG_F;
        endcase
        return seg;
    endfunction

    // Width of a counter/index that spans 0..n-1, never narrower than 1 bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_hex_decoder
// Description : Combinational hex nibble to seven-segment decoder.
// Ports       : nibble (in, 4)  - hex digit to show
//               seg    (out, 7) - active-low segments {a,b,c,d,e,f,g}
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_driver
// Description : Multiplexed seven-segment scan driver. Shows NUM_DIGITS hex
//               digits of a DATA_W-bit value, split into pages selected
//               manually or rotated automatically, with optional leading-zero
//               blanking and a hold function that freezes the snapshot.
// Ports       : clock     (in)            system clock
//               reset     (in)            synchronous, active-high
//               value     (in, DATA_W)    value to display
//               page_mode (in)            0 = manual page_sel, 1 = auto-rotate
//               page_sel  (in, PAGE_W)    manual page index
//               blank_lz  (in)            leading-zero blanking enable
//               hold      (in)            freeze the displayed snapshot
//               anode     (out, NUM_DIGITS) digit enables
//               cathode   (out, 7)        segments {a..g}, 0 = lit
//               dp        (out)           decimal point, 0 = lit
//               page      (out, PAGE_W)   page currently shown
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int DATA_W           = 32,
    parameter int TICK_DIV         = 200000,
    parameter int PAGE_FRAMES      = 64,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    localparam int NUM_PAGES       = DATA_W / (4 * NUM_DIGITS),
    localparam int PAGE_W          = width_of(NUM_PAGES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     value,
    input  logic                  page_mode,
    input  logic [PAGE_W-1:0]     page_sel,
    input  logic                  blank_lz,
    input  logic                  hold,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            cathode,
    output logic                  dp,
    output logic [PAGE_W-1:0]     page
);

    localparam int IDX_W     = width_of(NUM_DIGITS);
    localparam int TICK_W    = $clog2(TICK_DIV);
    localparam int FRAME_W   = width_of(PAGE_FRAMES);
    localparam int PAGE_BITS = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]      c_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TICK_W-1:0]     c_TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [FRAME_W-1:0]    c_FRAME_LAST = FRAME_W'(PAGE_FRAMES - 1);
    localparam logic [PAGE_W-1:0]     c_PAGE_LAST  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam bit                    c_MULTI_PAGE = (NUM_PAGES > 1);

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [PAGE_W-1:0]  r_page;
    logic [DATA_W-1:0]  r_snapshot;
    // Outputs stay inactive until the first tick has selected a digit.
    logic               r_started;

    logic               w_tick;
    logic               w_frame_start;
    logic               w_sel_valid;
    logic [PAGE_W-1:0]  w_page_next;
    logic [FRAME_W-1:0] w_frame_next;

    assign w_tick        = (r_tick_cnt == c_TICK_LAST);
    // The index wraps to 0 on this tick, so a new frame begins here.
    assign w_frame_start = w_tick && (r_idx == c_IDX_LAST);
    assign w_sel_valid   = (int'(page_sel) < NUM_PAGES);

    always_comb begin
        w_page_next  = r_page;
        w_frame_next = r_frame_cnt;
        if (page_mode) begin
            if (r_frame_cnt == c_FRAME_LAST) begin
                w_frame_next = '0;
                w_page_next  = (r_page == c_PAGE_LAST) ? '0 : r_page + 1'b1;
            end else begin
                w_frame_next = r_frame_cnt + 1'b1;
            end
        end else begin
            // Manual mode keeps the frame counter cleared so that auto
            // rotation always begins with a full page period.
            w_frame_next = '0;
            w_page_next  = w_sel_valid ? page_sel : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_idx       <= c_IDX_LAST;
            r_frame_cnt <= '0;
            r_page      <= '0;
            r_snapshot  <= '0;
            r_started   <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                r_started <= 1'b1;
            end
            // Snapshot and page only move at frame start, so a frame never
            // mixes two values or two pages.
            if (w_frame_start) begin
                if (!hold) begin
                    r_snapshot <= value;
                end
                r_page      <= w_page_next;
                r_frame_cnt <= w_frame_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and blanking
    // ------------------------------------------------------------------
    logic [PAGE_BITS-1:0]  w_page_bits;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_blank_vec;
    logic                  w_zero_run;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_anode_onehot;
    logic                  w_dp_lit;

    always_comb begin
        w_page_bits = '0;
        for (int p = 0; p < NUM_PAGES; p++) begin
            if (int'(r_page) == p) begin
                w_page_bits = r_snapshot[p*PAGE_BITS +: PAGE_BITS];
            end
        end
    end

    assign w_nibble = w_page_bits[{r_idx, 2'b00} +: 4];

    // Walk from the most significant digit down; a digit is blankable while
    // it and every digit above it are zero. Digit 0 always stays visible.
    always_comb begin
        w_zero_run  = 1'b1;
        w_blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (w_page_bits[4*i +: 4] == 4'h0);
            if (i > 0) begin
                w_blank_vec[i] = w_zero_run;
            end
        end
    end

    assign w_blank = blank_lz & w_blank_vec[r_idx];

    ssd_hex_decoder u_hex_decoder (
        .nibble (w_nibble),
        .seg    (w_seg)
    );

    assign w_anode_onehot = NUM_DIGITS'(1) << r_idx;

    // The decimal point marks the page number by lighting that digit.
    assign w_dp_lit = c_MULTI_PAGE
                   && (int'(r_page) < NUM_DIGITS)
                   && (int'(r_page) == int'(r_idx));

    // ------------------------------------------------------------------
    // Registered pin drivers, one clock behind the scan state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            anode   <= c_ANODE_OFF;
            cathode <= c_SEG_BLANK;
            dp      <= 1'b1;
            page    <= '0;
        end else if (r_started) begin
            // XOR with the off pattern applies the anode polarity.
            anode   <= w_anode_onehot ^ c_ANODE_OFF;
            cathode <= w_blank ? c_SEG_BLANK : w_seg;
            dp      <= ~w_dp_lit;
            page    <= r_page;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_driver
// Description : Directed self-checking bench for ssd_scan_driver with
//               NUM_DIGITS=4, DATA_W=32, TICK_DIV=4, PAGE_FRAMES=2 and
//               active-low anodes. Inputs change at falling edges right after
//               a frame's first digit appears, so they apply to the next frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;

    localparam int NUM_DIGITS  = 4;
    localparam int DATA_W      = 32;
    localparam int TICK_DIV    = 4;
    localparam int PAGE_FRAMES = 2;

    localparam logic [6:0] S_0   = 7'b0000001;
    localparam logic [6:0] S_1   = 7'b1001111;
    localparam logic [6:0] S_3   = 7'b0000110;
    localparam logic [6:0] S_4   = 7'b1001100;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_B   = 7'b1100000;
    localparam logic [6:0] S_C   = 7'b0110001;
    localparam logic [6:0] S_D   = 7'b1000010;
    localparam logic [6:0] S_E   = 7'b0110000;
    localparam logic [6:0] S_F   = 7'b0111000;
    localparam logic [6:0] S_OFF = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        page_mode;
    logic [0:0]  page_sel;
    logic        blank_lz;
    logic        hold;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic [0:0]  page;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ssd_scan_driver #(
        .NUM_DIGITS       (NUM_DIGITS),
        .DATA_W           (DATA_W),
        .TICK_DIV         (TICK_DIV),
        .PAGE_FRAMES      (PAGE_FRAMES),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .value     (value),
        .page_mode (page_mode),
        .page_sel  (page_sel),
        .blank_lz  (blank_lz),
        .hold      (hold),
        .anode     (anode),
        .cathode   (cathode),
        .dp        (dp),
        .page      (page)
    );

    task automatic chk_outputs(input string tag, input logic [3:0] exp_an,
                               input logic [6:0] exp_ca, input logic exp_dp,
                               input logic exp_pg);
        checks++;
        assert (anode === exp_an) else begin
            errors++;
            $error("FAIL %s anode observed %b expected %b", tag, anode, exp_an);
        end
        checks++;
        assert (cathode === exp_ca) else begin
            errors++;
            $error("FAIL %s cathode observed %b expected %b", tag, cathode, exp_ca);
        end
        checks++;
        assert (dp === exp_dp) else begin
            errors++;
            $error("FAIL %s dp observed %b expected %b", tag, dp, exp_dp);
        end
        checks++;
        assert (page === exp_pg) else begin
            errors++;
            $error("FAIL %s page observed %b expected %b", tag, page, exp_pg);
        end
    endtask

    // Checks ndig digits of a frame, 4 clocks each, starting on the first
    // clock of digit 0 and leaving the bench on the clock after the last one.
    task automatic check_frame(input string tag,
                               input logic [6:0] c0, input logic [6:0] c1,
                               input logic [6:0] c2, input logic [6:0] c3,
                               input int dp_digit, input logic pg, input int ndig);
        logic [6:0] cs [4];
        logic [3:0] an;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        for (int d = 0; d < ndig; d++) begin
            an = 4'b1111;
            an[d] = 1'b0;
            for (int k = 0; k < TICK_DIV; k++) begin
                chk_outputs($sformatf("%s_d%0d_c%0d", tag, d, k), an, cs[d],
                            (d == dp_digit) ? 1'b0 : 1'b1, pg);
                @(negedge clock);
            end
        end
    endtask

    // After reset release the first digit appears on the 5th clock.
    task automatic check_startup(input string tag);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            checks++;
            assert (anode === 4'b1111) else begin
                errors++;
                $error("FAIL %s_clk%0d anode observed %b expected 1111", tag, i, anode);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        reset     = 1'b1;
        value     = 32'h0000_1A3F;
        page_mode = 1'b0;
        page_sel  = 1'b0;
        blank_lz  = 1'b0;
        hold      = 1'b0;

        repeat (3) @(negedge clock);
        chk_outputs("reset", 4'b1111, S_OFF, 1'b1, 1'b0);
        reset = 1'b0;
        check_startup("startup");

        // Frame A shows 1A3F; blanking has no effect on it.
        value    = 32'h0000_0040;
        blank_lz = 1'b1;
        check_frame("frA_1a3f", S_F, S_3, S_A, S_1, 0, 1'b0, 4);

        // Frame B: 0x40 with leading zeros blanked.
        value = 32'h0000_0000;
        check_frame("frB_40", S_0, S_4, S_OFF, S_OFF, 0, 1'b0, 4);

        // Frame C: zero shows only digit 0.
        value    = 32'hDEAD_BEEF;
        page_sel = 1'b1;
        check_frame("frC_zero", S_0, S_OFF, S_OFF, S_OFF, 0, 1'b0, 4);

        // Frame D: page 1 of DEADBEEF; page_sel change mid-frame ignored.
        page_sel = 1'b0;
        check_frame("frD_p1", S_D, S_A, S_E, S_D, 1, 1'b1, 4);

        // Frame E: page 0 takes effect at this frame start.
        page_mode = 1'b1;
        check_frame("frE_p0", S_F, S_E, S_E, S_B, 0, 1'b0, 4);

        // Auto rotation: page toggles every two frames.
        check_frame("frF_auto_p0", S_F, S_E, S_E, S_B, 0, 1'b0, 4);
        check_frame("frG_auto_p1", S_D, S_A, S_E, S_D, 1, 1'b1, 4);
        check_frame("frH_auto_p1", S_D, S_A, S_E, S_D, 1, 1'b1, 4);

        // Hold freezes DEADBEEF while rotation continues.
        hold  = 1'b1;
        value = 32'h1234_5678;
        check_frame("frI_auto_p0", S_F, S_E, S_E, S_B, 0, 1'b0, 4);
        check_frame("frJ_hold_p0", S_F, S_E, S_E, S_B, 0, 1'b0, 4);
        check_frame("frK_hold_p1", S_D, S_A, S_E, S_D, 1, 1'b1, 4);
        check_frame("frL_hold_p1", S_D, S_A, S_E, S_D, 1, 1'b1, 2);

        // Now on the first clock of digit 2; reset mid-frame.
        chk_outputs("frL_d2", 4'b1011, S_E, 1'b1, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk_outputs("mid_reset", 4'b1111, S_OFF, 1'b1, 1'b0);

        value     = 32'h0000_00C0;
        hold      = 1'b0;
        page_mode = 1'b0;
        page_sel  = 1'b0;
        reset     = 1'b0;
        check_startup("restart");
        check_frame("frM_c0", S_0, S_C, S_OFF, S_OFF, 0, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
